// File: rtl/crc_pkg.sv
// Shared types and default widths for the CRC job scheduler (crc_sched) and its arbiter.
// The job descriptor is sized by the package defaults below.
package crc_pkg;

    localparam int CRC_ADDR_W = 10;
    localparam int CRC_DATA_W = 8;
    localparam int CRC_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_CLEAR,
        ST_FETCH,
        ST_WAIT,
        ST_PROCESS,
        ST_CHECK,
        ST_DONE
    } crc_sched_state_t;

    typedef struct packed {
        logic [CRC_ADDR_W-1:0] base;
        logic [CRC_ADDR_W-1:0] len;
        logic [CRC_W-1:0]      exp;
        logic                  owner;
    } crc_job_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/crc_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. The last-served pointer moves only when
// update is high with at least one request present; it resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       winner,
    output logic       any_req
);

    logic last_q;
    logic last_d;

    always_comb begin
        any_req = |req;
        // A tie goes to whoever was not served last; a lone requester always wins.
        winner  = (req == 2'b11) ? ~last_q : req[1];
        last_d  = last_q;
        if (update && any_req) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/crc_sched.sv
// crc_sched: shares one memory read port and a crc_calc engine between two requesters,
// walking each job's address range and reporting the CRC check. Define CRC_SCHED_STATS_EN for err_cnt.
module crc_sched #(
    parameter int ADDR_W  = crc_pkg::CRC_ADDR_W,
    parameter int DATA_W  = crc_pkg::CRC_DATA_W,
    parameter int CRC_W   = crc_pkg::CRC_W,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk50m,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0][ADDR_W-1:0] req_base,
    input  logic [1:0][ADDR_W-1:0] req_len,
    input  logic [1:0][CRC_W-1:0]  req_exp,
    output logic [1:0]             ack,
    output logic [1:0]             done,
    output logic                   result_ok,
    output logic [CRC_W-1:0]       result_crc,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   crc_clr,
    output logic                   crc_en,
    output logic [DATA_W-1:0]      crc_data,
    input  logic [CRC_W-1:0]       crc_value
`ifdef CRC_SCHED_STATS_EN
    ,
    output logic [15:0]            err_cnt
`endif
);

    import crc_pkg::*;

    localparam int                WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

    crc_sched_state_t  state_q, state_d;
    crc_job_t          job_q, job_d;
    logic [ADDR_W:0]   offset_q, offset_d;
    logic [ADDR_W:0]   len_ext;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              result_ok_q, result_ok_d;
    logic [CRC_W-1:0]  result_crc_q, result_crc_d;
    logic              arb_winner;
    logic              arb_any;
    logic              arb_update;
    logic              mismatch;

    rr_arb2 u_arb (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .req     (req),
        .update  (arb_update),
        .winner  (arb_winner),
        .any_req (arb_any)
    );

    // A zero length stands for the whole address space, hence the extra offset bit.
    assign len_ext  = (job_q.len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, job_q.len};
    assign mismatch = (crc_value != job_q.exp);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        job_d        = job_q;
        offset_d     = offset_q;
        wait_d       = wait_q;
        mem_addr_d   = mem_addr_q;
        result_ok_d  = result_ok_q;
        result_crc_d = result_crc_q;
        arb_update   = 1'b0;
        ack          = '0;
        done         = '0;
        mem_rd       = 1'b0;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_update  = 1'b1;
                    job_d.owner = arb_winner;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (req[job_q.owner]) begin
                    ack       = owner_onehot(job_q.owner);
                    job_d.base = req_base[job_q.owner];
                    job_d.len  = req_len[job_q.owner];
                    job_d.exp  = req_exp[job_q.owner];
                    offset_d  = '0;
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                crc_clr    = 1'b1;
                mem_addr_d = job_q.base;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd  = 1'b1;
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_PROCESS;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_PROCESS: begin
                crc_en   = 1'b1;
                offset_d = offset_q + 1'b1;
                if (offset_d == len_ext) begin
                    state_d = ST_CHECK;
                end else begin
                    // The address register leads FETCH so it is stable from FETCH through PROCESS.
                    mem_addr_d = job_q.base + offset_d[ADDR_W-1:0];
                    state_d    = ST_FETCH;
                end
            end
            ST_CHECK: begin
                result_crc_d = crc_value;
                result_ok_d  = !mismatch;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                done    = owner_onehot(job_q.owner);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            job_q        <= '0;
            offset_q     <= '0;
            wait_q       <= '0;
            mem_addr_q   <= '0;
            result_ok_q  <= 1'b0;
            result_crc_q <= '0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            offset_q     <= offset_d;
            wait_q       <= wait_d;
            mem_addr_q   <= mem_addr_d;
            result_ok_q  <= result_ok_d;
            result_crc_q <= result_crc_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign mem_addr   = mem_addr_q;
    assign crc_data   = mem_data;
    assign result_ok  = result_ok_q;
    assign result_crc = result_crc_q;

`ifdef CRC_SCHED_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == ST_CHECK && mismatch && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_sched.sv
// Self-checking bench for crc_sched with a byte memory and a CRC-16/CCITT-FALSE engine model;
// a scoreboard of expected job results is checked whenever done pulses.
module tb_crc_sched;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int CW = 16;

    logic                clk50m = 1'b0;
    logic                rst_n;
    logic [1:0]          req;
    logic [1:0][AW-1:0]  req_base;
    logic [1:0][AW-1:0]  req_len;
    logic [1:0][CW-1:0]  req_exp;
    logic [1:0]          ack;
    logic [1:0]          done;
    logic                result_ok;
    logic [CW-1:0]       result_crc;
    logic                busy;
    logic [AW-1:0]       mem_addr;
    logic                mem_rd;
    logic [DW-1:0]       mem_data;
    logic                crc_clr;
    logic                crc_en;
    logic [DW-1:0]       crc_data;
    logic [CW-1:0]       crc_value;
`ifdef CRC_SCHED_STATS_EN
    logic [15:0]         err_cnt;
`endif

    always #10 clk50m = ~clk50m;

    crc_sched #(.ADDR_W(AW), .DATA_W(DW), .CRC_W(CW), .MEM_LAT(1)) dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .req        (req),
        .req_base   (req_base),
        .req_len    (req_len),
        .req_exp    (req_exp),
        .ack        (ack),
        .done       (done),
        .result_ok  (result_ok),
        .result_crc (result_crc),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .crc_clr    (crc_clr),
        .crc_en     (crc_en),
        .crc_data   (crc_data),
        .crc_value  (crc_value)
`ifdef CRC_SCHED_STATS_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    // Memory with one-cycle read latency that holds its last read word; CRC engine registered.
    logic [7:0]  mem [0:1023];
    logic [7:0]  rdata_q = 8'h00;
    logic [15:0] crc_q   = 16'h0000;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        end
        return x;
    endfunction

    function automatic logic [15:0] range_crc(input logic [AW-1:0] base, input logic [AW-1:0] len);
        int          n;
        logic [15:0] c;
        n = (len == 0) ? 1024 : int'(len);
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = crc16_byte(c, mem[(int'(base) + i) % 1024]);
        end
        return c;
    endfunction

    always @(posedge clk50m) begin
        if (mem_rd) rdata_q <= mem[mem_addr];
    end
    assign mem_data = rdata_q;

    always @(posedge clk50m) begin
        if (crc_clr)     crc_q <= 16'hFFFF;
        else if (crc_en) crc_q <= crc16_byte(crc_q, crc_data);
    end
    assign crc_value = crc_q;

    typedef struct {
        logic        owner;
        logic [15:0] crc;
        logic        ok;
        int          lat;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            grant_cyc = 0;
    int            last_done_cyc = 0;
    int            en_cnt = 0;
    int            done_cnt = 0;
    int            ack_cnt[2] = '{0, 0};
    int            exp_err = 0;
    logic [AW-1:0] addr_log[$];

    function automatic logic [34:0] out_vec();
        return {ack, done, result_ok, result_crc, busy, mem_addr, mem_rd, crc_clr, crc_en};
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk50m);
        cyc++;
        if (ack != 2'b00 || done != 2'b00) begin
            checks++;
            if ($countones(ack) + $countones(done) != 1) begin
                errors++;
                $display("FAIL single_pulse ack=%b done=%b required exactly one pulse bit", ack, done);
            end
        end
        if (ack != 2'b00) begin
            grant_cyc = cyc;
            ack_cnt[ack[1]]++;
        end
        if (mem_rd) addr_log.push_back(mem_addr);
        if (crc_en) en_cnt++;
        if (done != 2'b00) begin
            done_cnt++;
            last_done_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done done=%b required no done", done);
            end else begin
                mon_e = sb.pop_front();
                if (done !== (mon_e.owner ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL done_owner done=%b required owner %0d", done, mon_e.owner);
                end
                checks++;
                if (result_ok !== mon_e.ok) begin
                    errors++;
                    $display("FAIL result_ok got=%b required=%b", result_ok, mon_e.ok);
                end
                checks++;
                if (result_crc !== mon_e.crc) begin
                    errors++;
                    $display("FAIL result_crc got=%h required=%h", result_crc, mon_e.crc);
                end
                checks++;
                if (cyc - grant_cyc != mon_e.lat) begin
                    errors++;
                    $display("FAIL done_latency got=%0d required=%0d", cyc - grant_cyc, mon_e.lat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] req_init);
        rst_n = 1'b0;
        req   = req_init;
        sb.delete();
        exp_err = 0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic push_job(input logic owner, input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [15:0] exp);
        exp_t e;
        int   n;
        n       = (len == 0) ? 1024 : int'(len);
        e.owner = owner;
        e.crc   = range_crc(base, len);
        e.ok    = (e.crc == exp);
        e.lat   = 3 + 3 * n;
        if (!e.ok) exp_err++;
        sb.push_back(e);
    endtask

    task automatic set_job(input logic owner, input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [15:0] exp);
        req_base[owner] = base;
        req_len[owner]  = len;
        req_exp[owner]  = exp;
    endtask

    task automatic wait_ack(input logic owner);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            @(negedge clk50m);
            k++;
            if (ack[owner]) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout owner=%0d ack=%b required ack within 200 cycles", owner, ack);
        end
        @(posedge clk50m);
        #1;
        req[owner] = 1'b0;
    endtask

    task automatic start_job(input logic owner, input logic [AW-1:0] base, input logic [AW-1:0] len,
                             input logic [15:0] exp);
        set_job(owner, base, len, exp);
        push_job(owner, base, len, exp);
        req[owner] = 1'b1;
        wait_ack(owner);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            @(negedge clk50m);
            k++;
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            errors++;
            $display("FAIL idle_timeout pending=%0d busy=%b required idle within %0d cycles",
                     sb.size(), busy, budget);
        end
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", out_vec());
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL idle_outputs got=%h required=0", out_vec());
        end
`ifdef CRC_SCHED_STATS_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_cnt got=%0d required=0", err_cnt);
        end
`endif
    endtask

    task automatic test_single();
        int a0;
        a0 = ack_cnt[0];
        start_job(1'b0, 10'h100, 10'd9, 16'h29B1);
        wait_idle(100);
        tick(3);
        checks++;
        if (ack_cnt[0] - a0 != 1) begin
            errors++;
            $display("FAIL single_ack_count got=%0d required=1", ack_cnt[0] - a0);
        end
        checks++;
        if (result_ok !== 1'b1 || result_crc !== 16'h29B1) begin
            errors++;
            $display("FAIL single_held ok=%b crc=%h required ok=1 crc=29b1", result_ok, result_crc);
        end
    endtask

    task automatic test_mismatch();
        start_job(1'b0, 10'h100, 10'd9, 16'h0000);
        wait_idle(100);
        checks++;
        if (result_ok !== 1'b0 || result_crc !== 16'h29B1) begin
            errors++;
            $display("FAIL mismatch_held ok=%b crc=%h required ok=0 crc=29b1", result_ok, result_crc);
        end
`ifdef CRC_SCHED_STATS_EN
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL err_cnt got=%0d required=%0d", err_cnt, exp_err);
        end
`endif
    endtask

    task automatic test_simultaneous();
        logic [15:0] e0, e1;
        e0 = range_crc(10'h100, 10'd2);
        e1 = range_crc(10'h200, 10'd3);
        set_job(1'b0, 10'h100, 10'd2, e0);
        set_job(1'b1, 10'h200, 10'd3, e1);
        do_reset(2'b11);
        push_job(1'b0, 10'h100, 10'd2, e0);
        push_job(1'b1, 10'h200, 10'd3, e1);
        wait_ack(1'b0);
        wait_ack(1'b1);
        checks++;
        if (grant_cyc - last_done_cyc != 2) begin
            errors++;
            $display("FAIL second_grant_gap got=%0d required=2", grant_cyc - last_done_cyc);
        end
        wait_idle(100);
        // A lone req0 job leaves requester 0 as last served, so the next tie goes to requester 1.
        start_job(1'b0, 10'h050, 10'd1, range_crc(10'h050, 10'd1));
        wait_idle(100);
        set_job(1'b0, 10'h010, 10'd2, 16'hBEEF);
        set_job(1'b1, 10'h020, 10'd2, range_crc(10'h020, 10'd2));
        push_job(1'b1, 10'h020, 10'd2, range_crc(10'h020, 10'd2));
        push_job(1'b0, 10'h010, 10'd2, 16'hBEEF);
        req = 2'b11;
        wait_ack(1'b1);
        wait_ack(1'b0);
        wait_idle(100);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        addr_log.delete();
        start_job(1'b0, 10'h3FE, 10'd4, range_crc(10'h3FE, 10'd4));
        wait_idle(100);
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_read_count got=%0d required=4", addr_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) begin
                checks++;
                if (addr_log[i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got=%h required=%h", i, addr_log[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_full_sweep();
        int en0;
        en0 = en_cnt;
        start_job(1'b1, 10'h155, 10'd0, range_crc(10'h155, 10'd0));
        wait_idle(3200);
        checks++;
        if (en_cnt - en0 != 1024) begin
            errors++;
            $display("FAIL sweep_crc_en got=%0d required=1024", en_cnt - en0);
        end
    endtask

    task automatic test_reset_mid_job();
        int k;
        int d0;
        addr_log.delete();
        start_job(1'b0, 10'h100, 10'd9, 16'h29B1);
        k = 0;
        while (addr_log.size() < 5 && k < 40) begin
            @(negedge clk50m);
            k++;
        end
        checks++;
        if (addr_log.size() < 5) begin
            errors++;
            $display("FAIL midjob_reach_byte5 reads=%0d required=5", addr_log.size());
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_err = 0;
        d0 = done_cnt;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL midjob_reset_outputs got=%h required=0", out_vec());
        end
        tick(2);
        rst_n = 1'b1;
        tick(40);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midjob_no_done got=%0d done pulses required=0", done_cnt - d0);
        end
        start_job(1'b0, 10'h100, 10'd9, 16'h29B1);
        wait_idle(100);
        checks++;
        if (result_ok !== 1'b1 || result_crc !== 16'h29B1) begin
            errors++;
            $display("FAIL after_reset_job ok=%b crc=%h required ok=1 crc=29b1", result_ok, result_crc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
        for (int i = 0; i < 9; i++) mem[10'h100 + i] = 8'(8'h31 + i);
        rst_n    = 1'b0;
        req      = '0;
        req_base = '0;
        req_len  = '0;
        req_exp  = '0;
        test_reset();
        test_single();
        test_mismatch();
        test_simultaneous();
        test_wrap();
        test_full_sweep();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_sched.md
# crc_sched

- Sequences and shares the CRC datapath (single-port 1024×8 memory read port plus `crc_calc` engine) between two requesters.
- Each job names a base address, a byte length and an expected CRC; the block walks the range, feeds the engine, compares the result and reports pass/fail to the job owner.
- Sits between the system requesters (host interface, self-test logic) and the memory/`crc_calc` pair; it replaces ad-hoc full-memory sweeps.

## Interface
- `ADDR_W`, 10, memory address width; lengths are also `ADDR_W` bits.
- `DATA_W`, 8, memory/CRC data width.
- `CRC_W`, 16, CRC width.
- `MEM_LAT`, 1, memory read latency in cycles (≥1).

- `clk50m`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  [1:0]  job request per requester; held high until `ack`.
- `req_base`  in  [1:0][ADDR_W-1:0]  first address of job.
- `req_len`  in  [1:0][ADDR_W-1:0]  byte count; 0 means 2^ADDR_W.
- `req_exp`  in  [1:0][CRC_W-1:0]  expected CRC.
- `ack`  out  [1:0]  one-cycle pulse; job accepted, parameters sampled.
- `done`  out  [1:0]  one-cycle pulse to the owning requester; `result_ok`/`result_crc` valid.
- `result_ok`  out  1  last job CRC matched `req_exp`; held until next `done`.
- `result_crc`  out  [CRC_W-1:0]  last computed CRC; held until next `done`.
- `busy`  out  1  high from GRANT through DONE.
- `mem_addr`  out  [ADDR_W-1:0]  memory read address.
- `mem_rd`  out  1  memory read strobe.
- `mem_data`  in  [DATA_W-1:0]  read data, valid `MEM_LAT` cycles after `mem_rd`.
- `crc_clr`  out  1  reinitialise engine.
- `crc_en`  out  1  engine consumes `crc_data` this cycle.
- `crc_data`  out  [DATA_W-1:0]  = `mem_data`, combinational pass-through.
- `crc_value`  in  [CRC_W-1:0]  engine result, valid one cycle after last `crc_en`.
- `err_cnt`  out  [15:0]  failed-job counter; only with `CRC_SCHED_STATS_EN`.

## Operation
- States: IDLE, GRANT, CLEAR, FETCH, WAIT, PROCESS, CHECK, DONE.
- **IDLE:** if any `req`, go to GRANT with the arbitration winner.
- **Arbitration:** round-robin.
  - With both requesting, grant the requester not served last.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - A request dropped before `ack` is ignored.
- **GRANT:** `ack[winner]`=1; latch base, len, exp and owner; `offset`←0 → CLEAR.
- **CLEAR:** `crc_clr`=1 → FETCH.
- **FETCH:** `mem_addr`=base+offset, mod 2^ADDR_W (wraps 1023→0); `mem_rd`=1 → WAIT.
- **WAIT:** stays `MEM_LAT` cycles, counted by a wait counter → PROCESS.
- **PROCESS:** `crc_en`=1 and `offset`++.
  - If `offset`+1 == len (len 0 ⇒ 2^ADDR_W bytes), go to CHECK; else FETCH.
  - The offset counter is ADDR_W+1 bits.
- **CHECK:** register `result_crc`←`crc_value` and `result_ok`←(`crc_value`==exp) → DONE.
- **DONE:** `done[owner]`=1 → IDLE.
  - A new request is arbitrated on the next cycle.
  - Pending requests wait; nothing is pre-empted.
- A requester deasserting `req` after `ack` does not abort the job.
- Reset values: all outputs 0; state IDLE; last-served pointer 1; `err_cnt` 0.
- Reset mid-job: immediate return to IDLE with no `done`; the engine is not cleared until the next CLEAR.

## Timing
- Per byte: 2+`MEM_LAT` cycles (3 at default).
- GRANT is cycle 0; CLEAR is cycle 1; `done` is at cycle 3+N·(2+`MEM_LAT`) for N bytes.
- `mem_addr` is registered and stable from FETCH through PROCESS of the same byte.
- `ack` and `done` are never asserted for both requesters in the same cycle.

## Configuration
- `CRC_SCHED_STATS_EN` defined: `err_cnt` port exists.
  - Increments in CHECK when the CRC mismatches.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: `err_cnt` port and its counter are absent; all other behaviour identical.

## Structure
- Package `crc_pkg` holds:
  - the state enum `crc_sched_state_t`;
  - defaults `CRC_ADDR_W`=10, `CRC_DATA_W`=8, `CRC_W`=16;
  - a typedef for the job descriptor (base, len, exp, owner).
- One sub-module: `rr_arb2`, the 2-way round-robin arbiter with last-served pointer and a grant-update enable.

## Test plan
- **Single job:**
  - Memory 0x100–0x108 = "123456789"; engine is CRC-16/CCITT-FALSE.
  - req0, base 0x100, len 9, exp 0x29B1.
  - Required: `ack[0]` once; `done[0]` 30 cycles after GRANT; `result_ok`=1; `result_crc`=0x29B1.
- **Mismatch:** same job with exp 0x0000 → `result_ok`=0; `result_crc`=0x29B1; `err_cnt`=1 with STATS.
- **Simultaneous requests:**
  - req0 and req1 both high from reset → req0 granted first, req1 granted right after req0's `done`.
  - Both re-request → req1 served before req0.
- **Wrap:** base 0x3FE, len 4 → `mem_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001; `done` after 4 bytes.
- **Full sweep:** len 0 → 1024 `crc_en` pulses; `done` at cycle 3075.
- **Reset mid-job:**
  - `rst_n` low at byte 5 → all outputs 0 immediately, no `done`.
  - A new req0 afterwards completes normally with the correct CRC.
